// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and command payload for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned OPD_W = 4;
  localparam int unsigned CMD_W = OP_W + 2 * OPD_W;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    LATCH = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
  } cmd_t;

  // Ops 6/7 are undefined and a divide by zero is rejected before reaching the ALU.
  function automatic logic is_err_cmd(input cmd_t c);
    return (c.op == 3'd6) || (c.op == 3'd7) || ((c.op == OP_DIV) && (c.b == '0));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO with occupancy counter; head entry is visible combinationally.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to a registered ALU and returns results in order.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  output logic [2:0]             alu_op,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  input  logic [7:0]             alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  state_e           state;
  cmd_t             head;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_c;
  logic             pop_c;

  assign in_ready = !fifo_full;
  assign push_c   = in_valid && in_ready && !rst;
  assign head     = cmd_t'(head_raw);

  // Error heads leave straight from IDLE; valid heads leave at the end of EXEC.
  always_comb begin
    pop_c = 1'b0;
    if (state == EXEC) pop_c = 1'b1;
    else if ((state == IDLE) && !fifo_empty && is_err_cmd(head)) pop_c = 1'b1;
  end

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (CMD_W'({in_op, in_a, in_b})),
    .pop   (pop_c),
    .rdata (head_raw),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_err   <= 1'b0;
      alu_op    <= OP_NOP;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (is_err_cmd(head)) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_data  <= 8'h00;
              out_err   <= 1'b1;
            end else begin
              state  <= EXEC;
              alu_op <= head.op;
              alu_a  <= {4'b0000, head.a};
              alu_b  <= {4'b0000, head.b};
            end
          end
        end
        EXEC: state <= LATCH;
        // Operands stay put through LATCH so the registered ALU output is for this command.
        LATCH: begin
          state     <= RESP;
          out_valid <= 1'b1;
          out_data  <= alu_result;
          out_err   <= 1'b0;
          alu_op    <= OP_NOP;
          alu_a     <= 8'h00;
          alu_b     <= 8'h00;
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU model and an in-order response queue.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  logic saw_bad_op = 1'b0;
  logic [8:0] rq [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .count(count)
  );

  // Registered ALU: result appears one edge after the operands.
  always @(posedge clk) begin
    case (alu_op)
      3'd0:    alu_result <= alu_a + alu_b;
      3'd1:    alu_result <= alu_a - alu_b;
      3'd2:    alu_result <= alu_a * alu_b;
      3'd3:    alu_result <= (alu_b != 0) ? alu_a / alu_b : 8'h00;
      3'd4:    alu_result <= alu_a & alu_b;
      3'd5:    alu_result <= alu_a | alu_b;
      default: alu_result <= 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) rq.push_back({out_err, out_data});
  end

  always @(negedge clk) begin
    if (alu_op == 3'd3 || alu_op == 3'd6) saw_bad_op = 1'b1;
    if (out_valid) vld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  // One command from an empty idle sequencer with out_ready held high.
  task automatic single(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] d, input logic e, input int lat);
    push(op, a, b);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'(i == lat));
      if (i == 1 && lat == 3) begin
        check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
        check({tag, "_alu_ab"}, {16'h0, alu_a, alu_b}, {16'h0, 4'h0, a, 4'h0, b});
      end
    end
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_err"}, 32'(out_err), 32'(e));
    tick();
    check({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_resp(input int n);
    int cyc = 0;
    while (rq.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
    check("resp_timeout", 32'(rq.size() >= n), 32'd1);
  endtask

  task automatic check_resp(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = (rq.size() != 0) ? rq.pop_front() : 9'h1FF;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_alu_idle", {21'h0, alu_op, alu_a}, {21'h0, 3'd7, 8'h00});
    tick();
    check("rst_no_push", 32'(count), 32'd0);

    single("add", 3'd0, 4'd3, 4'd5, 8'h08, 1'b0, 3);
    single("sub", 3'd1, 4'd2, 4'd5, 8'hFD, 1'b0, 3);
    single("div0", 3'd3, 4'd9, 4'd0, 8'h00, 1'b1, 1);
    single("op6", 3'd6, 4'd1, 4'd2, 8'h00, 1'b1, 1);
    check("no_bad_alu_op", 32'(saw_bad_op), 32'd0);

    // Back-pressure: one response held in RESP, four queued, fifth refused.
    out_ready = 1'b0;
    rq.delete();
    push(3'd2, 4'd4, 4'd3);
    tick(); tick(); tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    push(3'd4, 4'hF, 4'h5);
    push(3'd5, 4'h1, 4'h2);
    push(3'd0, 4'hF, 4'hF);
    push(3'd1, 4'h0, 4'h1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_op = 3'd5; in_a = 4'h8; in_b = 4'h1;
    tick();
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_hold", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'h0C});
    out_ready = 1'b1;
    wait_resp(5);
    check_resp("ord_mul", 9'h00C);
    check_resp("ord_and", 9'h005);
    check_resp("ord_or", 9'h003);
    check_resp("ord_add", 9'h01E);
    check_resp("ord_sub", 9'h0FF);
    tick(); tick();
    check("drained", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2, across the pointer wrap.
    out_ready = 1'b0;
    rq.delete();
    push(3'd0, 4'h1, 4'h1);
    push(3'd7, 4'h0, 4'h0);
    push(3'd0, 4'h7, 4'h8);
    tick();
    check("sp_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd2; in_a = 4'hF; in_b = 4'hF;
    tick();
    in_valid = 1'b0;
    check("sp_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    wait_resp(4);
    check_resp("sp_r0", 9'h002);
    check_resp("sp_r1", 9'h100);
    check_resp("sp_r2", 9'h00F);
    check_resp("sp_r3", 9'h0E1);

    // Reset during LATCH with three commands still queued.
    tick(); tick();
    out_ready = 1'b0;
    rq.delete();
    push(3'd0, 4'h1, 4'h2);
    tick(); tick(); tick();
    push(3'd0, 4'h2, 4'h2);
    push(3'd0, 4'h3, 4'h3);
    push(3'd4, 4'h3, 4'h1);
    push(3'd5, 4'h4, 4'h1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("latch_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vld_cnt = 0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_alu", 32'(alu_op), 32'd7);
    repeat (10) tick();
    check("mid_rst_no_vld", 32'(vld_cnt), 32'd0);
    check("mid_rst_resp", 32'(rq.size()), 32'd1);
    single("post_rst", 3'd5, 4'hA, 4'h5, 8'h0F, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
